// File: rtl/tour_length_eval.sv
// tour_length_eval: sequential closed-tour length evaluator with best-length tracking
module tour_length_eval #(
  parameter int N_VERT = 64,
  parameter int COORD_W = 8,
  localparam int IDX_W = $clog2(N_VERT),
  localparam int D2_W = 2*COORD_W+1,
  localparam int R_W = COORD_W+1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [N_VERT*COORD_W-1:0] i_xs,
  input  logic [N_VERT*COORD_W-1:0] i_ys,
  input  logic [N_VERT*IDX_W-1:0]   i_path,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [15:0]               o_length,
  output logic [15:0]               o_best_length,
  output logic                      o_improved
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SQ, S_SQRT, S_ACC} state_t;
  state_t r_state;
  logic [N_VERT*IDX_W-1:0] r_snap;
  logic [IDX_W-1:0] r_k;
  logic [COORD_W-1:0] r_dx, r_dy;
  logic [D2_W-1:0] r_d2;
  logic [R_W-1:0] r_root, r_mask;
  logic [15:0] r_acc, r_length, r_best;
  logic r_busy, r_done, r_improved;
  logic [IDX_W-1:0] w_k1, w_va, w_vb;
  logic [COORD_W-1:0] w_xa, w_xb, w_ya, w_yb, w_dx, w_dy;
  logic [D2_W-1:0] w_dx_e, w_dy_e, w_d2;
  logic [R_W-1:0] w_trial;
  logic [2*R_W-1:0] w_trial_e;
  logic w_fits;
  logic [15:0] w_sum;
  assign w_k1 = (r_k == IDX_W'(N_VERT-1)) ? '0 : r_k + IDX_W'(1);
  assign w_va = r_snap[r_k*IDX_W +: IDX_W];
  assign w_vb = r_snap[w_k1*IDX_W +: IDX_W];
  assign w_xa = i_xs[w_va*COORD_W +: COORD_W];
  assign w_xb = i_xs[w_vb*COORD_W +: COORD_W];
  assign w_ya = i_ys[w_va*COORD_W +: COORD_W];
  assign w_yb = i_ys[w_vb*COORD_W +: COORD_W];
  assign w_dx = (w_xa > w_xb) ? w_xa - w_xb : w_xb - w_xa;
  assign w_dy = (w_ya > w_yb) ? w_ya - w_yb : w_yb - w_ya;
  assign w_dx_e = D2_W'(r_dx);
  assign w_dy_e = D2_W'(r_dy);
  assign w_d2 = w_dx_e*w_dx_e + w_dy_e*w_dy_e;
  assign w_trial = r_root | r_mask;
  assign w_trial_e = (2*R_W)'(w_trial);
  assign w_fits = w_trial_e*w_trial_e <= (2*R_W)'(r_d2);
  assign w_sum = r_acc + 16'(r_root);
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_length = r_length;
  assign o_best_length = r_best;
  assign o_improved = r_improved;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_snap <= '0;
      r_k <= '0;
      r_dx <= '0;
      r_dy <= '0;
      r_d2 <= '0;
      r_root <= '0;
      r_mask <= '0;
      r_acc <= '0;
      r_length <= '0;
      r_best <= '1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_improved <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_improved <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_snap <= i_path;
          r_acc <= '0;
          r_k <= '0;
          r_busy <= 1'b1;
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_dx <= w_dx;
          r_dy <= w_dy;
          r_state <= S_SQ;
        end
        S_SQ: begin
          r_d2 <= w_d2;
          r_root <= '0;
          r_mask <= {1'b1, {(R_W-1){1'b0}}};
          r_state <= S_SQRT;
        end
        S_SQRT: begin
          r_root <= w_fits ? w_trial : r_root;
          r_mask <= r_mask >> 1;
          r_state <= r_mask[0] ? S_ACC : S_SQRT;
        end
        S_ACC: begin
          r_acc <= w_sum;
          if (r_k == IDX_W'(N_VERT-1)) begin
            r_length <= w_sum;
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_best <= (w_sum < r_best) ? w_sum : r_best;
            r_improved <= w_sum < r_best;
            r_state <= S_IDLE;
          end else begin
            r_k <= w_k1;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tour_length_eval.sv
// tb_tour_length_eval: table-driven and randomized checks of tour_length_eval against a tour-length model
module tb_tour_length_eval;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] xs [64];
  logic [7:0] ys [64];
  logic [5:0] path [64];
  logic [511:0] xs_v, ys_v;
  logic [383:0] path_v;
  logic busy, done, improved;
  logic [15:0] length, best_length;
  int n_pass = 0;
  int n_total = 0;
  int m_best = 65535;
  typedef struct {int pat; int exp_len; int exp_imp; int exp_best;} vec_t;
  vec_t vecs [6];
  always #5 clk = ~clk;
  always_comb begin
    xs_v = '0;
    ys_v = '0;
    path_v = '0;
    for (int i = 0; i < 64; i++) begin
      xs_v[i*8 +: 8] = xs[i];
      ys_v[i*8 +: 8] = ys[i];
      path_v[i*6 +: 6] = path[i];
    end
  end
  tour_length_eval dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_xs(xs_v), .i_ys(ys_v), .i_path(path_v),
    .o_busy(busy), .o_done(done), .o_length(length),
    .o_best_length(best_length), .o_improved(improved)
  );
  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic int isqrt(input int v);
    int r = int'($floor($sqrt(real'(v))));
    while (r*r > v) r--;
    while ((r+1)*(r+1) <= v) r++;
    return r;
  endfunction
  function automatic int model_len();
    int s = 0;
    for (int k = 0; k < 64; k++) begin
      int a = int'(path[k]);
      int b = int'(path[(k+1) % 64]);
      int dx = int'(xs[a]) - int'(xs[b]);
      int dy = int'(ys[a]) - int'(ys[b]);
      s += isqrt(dx*dx + dy*dy);
    end
    return s;
  endfunction
  function automatic int model_update(input int len);
    int imp = (len < m_best) ? 1 : 0;
    if (imp == 1) m_best = len;
    return imp;
  endfunction
  task automatic set_pattern(input int p);
    for (int i = 0; i < 64; i++) begin
      path[i] = 6'(i);
      xs[i] = (p == 1) ? 8'(i) : (p == 4 && i % 2 == 1) ? 8'd255 : 8'd0;
      ys[i] = (p == 4 && i % 2 == 1) ? 8'd255 : 8'd0;
    end
    if (p == 2 || p == 3) begin
      xs[1] = 8'd3;
      ys[1] = 8'd4;
    end
    if (p == 3) begin
      for (int i = 1; i < 63; i++) path[i] = 6'(i+1);
      path[63] = 6'd1;
    end
  endtask
  task automatic set_random();
    for (int i = 0; i < 64; i++) begin
      xs[i] = 8'($urandom_range(0, 255));
      ys[i] = 8'($urandom_range(0, 255));
      path[i] = 6'($urandom_range(0, 63));
    end
  endtask
  task automatic wait_done(inout int lat);
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic run_eval(output int len, output int imp, output int lat);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    lat = 0;
    wait_done(lat);
    check("latency", lat, 768);
    check("busy_at_done", int'(busy), 0);
    len = int'(length);
    imp = int'(improved);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
  endtask
  initial begin
    int len, imp, lat, exp, cnt;
    vecs[0] = '{4, 23040, 1, 23040};
    vecs[1] = '{1, 126, 1, 126};
    vecs[2] = '{2, 10, 1, 10};
    vecs[3] = '{3, 10, 0, 10};
    vecs[4] = '{0, 0, 1, 0};
    vecs[5] = '{0, 0, 0, 0};
    set_pattern(0);
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_improved", int'(improved), 0);
    check("rst_length", int'(length), 0);
    check("rst_best", int'(best_length), 65535);
    rst_n = 1'b1;
    for (int v = 0; v < 6; v++) begin
      set_pattern(vecs[v].pat);
      run_eval(len, imp, lat);
      check($sformatf("vec%0d_length", v), len, vecs[v].exp_len);
      check($sformatf("vec%0d_improved", v), imp, vecs[v].exp_imp);
      check($sformatf("vec%0d_best", v), int'(best_length), vecs[v].exp_best);
    end
    m_best = 0;
    set_random();
    exp = model_len();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    for (int i = 0; i < 64; i++) path[i] = 6'($urandom_range(0, 63));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 100;
    wait_done(lat);
    check("snap_latency", lat, 768);
    check("snap_length", int'(length), exp);
    check("snap_improved", int'(improved), model_update(exp));
    cnt = 0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      cnt += int'(done);
    end
    check("snap_extra_done", cnt, 0);
    check("snap_busy_idle", int'(busy), 0);
    set_pattern(4);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cnt += int'(done);
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_best", int'(best_length), 65535);
    check("abort_length", int'(length), 0);
    m_best = 65535;
    repeat (3) begin
      @(negedge clk);
      cnt += int'(done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      cnt += int'(done);
    end
    check("abort_no_done", cnt, 0);
    set_random();
    exp = model_len();
    run_eval(len, imp, lat);
    check("post_abort_length", len, exp);
    check("post_abort_improved", imp, model_update(exp));
    check("post_abort_best", int'(best_length), m_best);
    for (int r = 0; r < 6; r++) begin
      set_random();
      if (r % 2 == 1)
        for (int i = 0; i < 64; i++) begin
          xs[i] = xs[i] >> 3;
          ys[i] = ys[i] >> 3;
        end
      exp = model_len();
      run_eval(len, imp, lat);
      check($sformatf("rand%0d_length", r), len, exp);
      check($sformatf("rand%0d_improved", r), imp, model_update(exp));
      check($sformatf("rand%0d_best", r), int'(best_length), m_best);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
